ring_step_gen: RTL and testbench
================================

# ring_step_gen

Step-enable generator for the ring counter. It produces the single-cycle `en` pulse that advances the ring position, at one of four selectable rates. Two raw push buttons drive it: one toggles run/pause, the other cycles the speed level. It sits directly upstream of the ring counter; `en` connects straight to the counter's enable input.

## Interface
Parameters:
- `BASE_DIV`, default 50_000_000: step period at speed level 0, in clocks. Must be ≥ 8.
- `DEB_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a button level change. Must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `btn_run`  in  1  raw asynchronous push button, active-high. Each press toggles run/pause.
- `btn_speed`  in  1  raw asynchronous push button, active-high. Each press advances the speed level.
- `en`  out  1  registered step pulse, one clock wide, feeds the ring counter enable.
- `running`  out  1  1 = stepping, 0 = paused.
- `speed_lvl`  out  2  current speed level, 0 (slowest) to 3.

## Operation
Reset:
- On `rst_n` = 0 at a clock edge, the following all clear: `en`, `running`, `speed_lvl`, the divider count, the debounce counters and state, and the synchronizer flops.
- The block leaves reset paused at level 0.

Button path (one per button):
- Two-flop synchronizer.
- Debounce counter. It increments while the synchronized value differs from the debounced state and clears when they are equal.
- When the counter is at `DEB_CYCLES`-1 and the values still differ, the debounced state flips and the counter clears.
- Press event: debounced rising edge, registered, one clock wide. Releases generate no event.

Run control:
- A run press toggles `running`.
- A speed press sets `speed_lvl` to `speed_lvl`+1 mod 4. Level 3 wraps to 0.
- Both presses in the same cycle: both are applied.

Divider:
- Step period P = `BASE_DIV` >> `speed_lvl`.
- The divider count is `$clog2(BASE_DIV)` bits and unsigned.
- While `running` = 0, the count is held at 0 and `en` = 0.
- While `running` = 1:
  - If count == P-1: count goes to 0 and `en` goes to 1.
  - Otherwise: count increments and `en` goes to 0.

Boundary rules:
- Pause press in the same cycle as terminal count: pause wins. `en` stays 0 and the count clears.
- Speed press while running: the count clears to 0 and any coincident `en` is suppressed. The new period P starts fresh.
- Run press (resume): the count starts from 0, so no partial period is carried over.
- Reset mid-operation overrides all events in that cycle.

## Timing
- `en` is high for exactly 1 clock.
- The first `en` occurs exactly P clocks after the edge at which `running` rises. After that, `en` repeats every P clocks while running and `speed_lvl` is unchanged.
- Press latency: `running` or `speed_lvl` changes DEB_CYCLES+4 clocks after the first edge that samples the raw button high.
  - Budget: 2 sync + DEB_CYCLES debounce + 1 event register + 1 update.
  - Tolerance is ±1 for asynchronous input sampling.
- A raw pulse or glitch shorter than DEB_CYCLES clocks causes no event.
- Period by level: 0 → `BASE_DIV`, 1 → `BASE_DIV`/2, 2 → `BASE_DIV`/4, 3 → `BASE_DIV`/8 (truncating shift).

## Structure
- Shared package `ring_pkg`:
  - `SPEED_W` = 2
  - `NUM_LEVELS` = 4
  - typedef `speed_t` (logic [1:0])
  - Same package the ring counter side uses for its position constants.
- Sub-module `btn_debounce`, instantiated twice. It contains the synchronizer, the debounce counter and the registered rising-edge event. Its parameter is `DEB_CYCLES`; its outputs are `level` and `press`.
- The top level holds the run/speed registers and the divider.

## Test plan
Use `BASE_DIV`=16 and `DEB_CYCLES`=4.
1. **Reset:** hold `rst_n`=0 for 2 clocks, then release → `en`=0, `running`=0, `speed_lvl`=0. No `en` for the next 100 clocks.
2. **Start:** hold `btn_run`=1 for 10 clocks → `running` rises 8±1 clocks after assertion. `en` pulses 1 clock wide, first at 16 clocks, then every 16 clocks.
3. **Glitch rejection:** 3-clock `btn_run` pulse, then 2-clock pulses with 1-clock gaps → no change to `running` and no event.
4. **Speed cycling while running:** successive clean speed presses → periods 8, 4, 2. The 4th press wraps to level 0 with period 16. Each press restarts the count and suppresses a coincident `en`.
5. **Pause/resume:** time the pause event to land on terminal count → no `en` in that cycle and `running`=0. Resume → first `en` exactly 16 clocks after `running` rises.
6. **Reset mid-run:** at level 2 with count 3, drive `rst_n`=0 → at the next edge `en`=0, `running`=0, `speed_lvl`=0. Simultaneous run and speed presses after that → `running`=1 and `speed_lvl`=1.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared constants and types for the ring counter and its step generator.
package ring_pkg;

  localparam int SPEED_W    = 2;
  localparam int NUM_LEVELS = 4;
  localparam int RING_LEN   = 8;
  localparam int RING_W     = $clog2(RING_LEN);

  typedef logic [SPEED_W-1:0] speed_t;

  // Each speed level halves the step period (truncating).
  function automatic int unsigned step_period(int unsigned base_div, speed_t lvl);
    return base_div >> lvl;
  endfunction

endpackage

// File: rtl/ring_step_gen_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, stability counter and
// a registered one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_step_gen.sv
// Step-enable generator for the ring counter: run/pause and four-level speed
// control from two push buttons, and a divider producing a one-cycle en pulse.
module ring_step_gen
  import ring_pkg::*;
#(
  parameter int BASE_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   btn_run,
  input  logic   btn_speed,
  output logic   en,
  output logic   running,
  output speed_t speed_lvl
);

  localparam int CW = $clog2(BASE_DIV);

  logic          run_press;
  logic          spd_press;
  logic          run_level;
  logic          spd_level;
  logic          unused_levels;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_run),
    .level (run_level),
    .press (run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_speed),
    .level (spd_level),
    .press (spd_press)
  );

  // Debounced levels are only of interest to status logic elsewhere.
  assign unused_levels = run_level ^ spd_level;

  assign cnt_last = CW'(step_period(BASE_DIV, speed_lvl) - 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running   <= 1'b0;
      speed_lvl <= '0;
      cnt       <= '0;
      en        <= 1'b0;
    end else begin
      en <= 1'b0;
      if (run_press) running <= ~running;
      if (spd_press) speed_lvl <= speed_lvl + 2'd1;
      // Any press restarts the period and swallows a coincident terminal count.
      if (run_press || spd_press || !running) begin
        cnt <= '0;
      end else if (cnt == cnt_last) begin
        cnt <= '0;
        en  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_step_gen.sv
// Randomized bench for ring_step_gen with a cycle-indexed behavioural model.
module tb_ring_step_gen;
  import ring_pkg::*;

  localparam int BASE_DIV = 16;
  localparam int DEB      = 4;
  localparam int NCYC     = 8192;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   btn_run = 1'b0;
  logic   btn_speed = 1'b0;
  logic   en;
  logic   running;
  speed_t speed_lvl;

  ring_step_gen #(.BASE_DIV(BASE_DIV), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_run   (btn_run),
    .btn_speed (btn_speed),
    .en        (en),
    .running   (running),
    .speed_lvl (speed_lvl)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic       en_log  [NCYC];
  logic       run_log [NCYC];
  logic [1:0] lvl_log [NCYC];
  logic       exp_en  [NCYC];
  logic       exp_run [NCYC];
  logic [1:0] exp_lvl [NCYC];
  bit         ev_run  [NCYC];
  bit         ev_spd  [NCYC];

  int m_run = 0;
  int m_lvl = 0;
  int anchor = 0;
  int model_pos = 0;
  int lat = DEB + 4;

  // Edge k is logged at index k, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (cyc < NCYC - 1) cyc = cyc + 1;
    en_log[cyc]  = en;
    run_log[cyc] = running;
    lvl_log[cyc] = speed_lvl;
  end

  // Reference: each press event toggles/advances state and restarts the period;
  // en fires at every multiple of the current period after the restart.
  function automatic void build_model(int a, int b);
    for (int c = a; c < b; c++) begin
      exp_en[c] = 1'b0;
      if (ev_run[c] || ev_spd[c]) begin
        if (ev_run[c]) m_run = 1 - m_run;
        if (ev_spd[c]) m_lvl = (m_lvl + 1) % 4;
        anchor = c;
      end else if (m_run == 1 && c > anchor &&
                   (c - anchor) % (BASE_DIV / (1 << m_lvl)) == 0) begin
        exp_en[c] = 1'b1;
      end
      exp_run[c] = (m_run == 1);
      exp_lvl[c] = 2'(m_lvl);
    end
  endfunction

  task automatic sync_model();
    build_model(model_pos, cyc + 1);
    model_pos = cyc + 1;
  endtask

  task automatic press_btns(input bit r, input bit s, input int hold, output int e);
    int k;
    k = cyc;
    btn_run = r;
    btn_speed = s;
    repeat (hold) @(negedge clk);
    btn_run = 1'b0;
    btn_speed = 1'b0;
    e = k + lat;
    if (hold >= DEB) begin
      ev_run[e] = r;
      ev_spd[e] = s;
    end
    repeat (DEB + 5) @(negedge clk);
  endtask

  task automatic test_reset();
    int a;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (en_log[cyc] !== 1'b0 || run_log[cyc] !== 1'b0 || lvl_log[cyc] !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got en=%b run=%b lvl=%0d want 0 0 0",
               en_log[cyc], run_log[cyc], lvl_log[cyc]);
    end
    model_pos = cyc + 1;
    anchor = cyc;
    a = model_pos;
    repeat (100) @(negedge clk);
    sync_model();
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL reset_idle c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  task automatic test_start();
    int a, k, obs, e;
    bit found;
    a = model_pos;
    k = cyc;
    found = 1'b0;
    obs = 0;
    btn_run = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 10) btn_run = 1'b0;
      if (!found && running === 1'b1) begin
        found = 1'b1;
        obs = cyc - k;
      end
    end
    n_cmp++;
    if (!found || obs < DEB + 3 || obs > DEB + 5) begin
      n_err++;
      $display("FAIL press_latency got %0d (seen=%0b) want %0d..%0d", obs, found, DEB + 3, DEB + 5);
    end else begin
      lat = obs;
    end
    e = k + lat;
    ev_run[e] = 1'b1;
    repeat (BASE_DIV * $urandom_range(3, 5) + 5) @(negedge clk);
    sync_model();
    n_cmp++;
    if (en_log[e + 16] !== 1'b1 || en_log[e + 15] !== 1'b0 || en_log[e + 17] !== 1'b0) begin
      n_err++;
      $display("FAIL first_en got %b%b%b at rise+15..17 want 010",
               en_log[e + 15], en_log[e + 16], en_log[e + 17]);
    end
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL start c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  task automatic test_glitch();
    int a;
    a = model_pos;
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
    repeat (2) @(negedge clk);
    repeat (3) begin
      btn_run = 1'b1;
      repeat (2) @(negedge clk);
      btn_run = 1'b0;
      @(negedge clk);
    end
    repeat (6) begin
      if ($urandom_range(0, 1) == 0) btn_run = 1'b1;
      else btn_speed = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
      btn_run = 1'b0;
      btn_speed = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (DEB + 8) @(negedge clk);
    sync_model();
    n_cmp++;
    if (run_log[cyc] !== 1'b1 || lvl_log[cyc] !== 2'd0) begin
      n_err++;
      $display("FAIL glitch_state got run=%b lvl=%0d want run=1 lvl=0", run_log[cyc], lvl_log[cyc]);
    end
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL glitch c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  task automatic test_speed();
    int a, e, p;
    int want_p [4] = '{8, 4, 2, 16};
    a = model_pos;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(3, 12)) @(negedge clk);
      if (i == 1) begin
        sync_model();
        p = BASE_DIV / (1 << m_lvl);
        for (int j = 0; j < 64 && ((cyc + lat - anchor) % p) != 0; j++) @(negedge clk);
      end
      press_btns(1'b0, 1'b1, $urandom_range(DEB + 1, DEB + 6), e);
      p = want_p[i];
      repeat (2 * p + 4) @(negedge clk);
      if (i == 1) begin
        n_cmp++;
        if (en_log[e] !== 1'b0) begin
          n_err++;
          $display("FAIL speed_suppress got en=%b at press edge want 0", en_log[e]);
        end
      end
      n_cmp++;
      if (lvl_log[e] !== 2'((i + 1) % 4) || en_log[e + p] !== 1'b1 || en_log[e + p - 1] !== 1'b0) begin
        n_err++;
        $display("FAIL speed_period press %0d got lvl=%0d en@P-1,P=%b%b want lvl=%0d en=01 (P=%0d)",
                 i, lvl_log[e], en_log[e + p - 1], en_log[e + p], (i + 1) % 4, p);
      end
    end
    sync_model();
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL speed c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  task automatic test_pause_resume();
    int a, e, e2;
    a = model_pos;
    sync_model();
    for (int j = 0; j < 64 && ((cyc + lat - anchor) % BASE_DIV) != 0; j++) @(negedge clk);
    press_btns(1'b1, 1'b0, $urandom_range(DEB + 1, DEB + 6), e);
    repeat ($urandom_range(5, 30)) @(negedge clk);
    n_cmp++;
    if (en_log[e] !== 1'b0 || run_log[e] !== 1'b0) begin
      n_err++;
      $display("FAIL pause_tc got en=%b run=%b want en=0 run=0", en_log[e], run_log[e]);
    end
    press_btns(1'b1, 1'b0, $urandom_range(DEB + 1, DEB + 6), e2);
    repeat (2 * BASE_DIV + 4) @(negedge clk);
    n_cmp++;
    if (run_log[e2] !== 1'b1 || run_log[e2 - 1] !== 1'b0 ||
        en_log[e2 + 16] !== 1'b1 || en_log[e2 + 15] !== 1'b0) begin
      n_err++;
      $display("FAIL resume_first got run=%b%b en@15,16=%b%b want run=01 en=01",
               run_log[e2 - 1], run_log[e2], en_log[e2 + 15], en_log[e2 + 16]);
    end
    sync_model();
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL pause c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a, e, r;
    a = model_pos;
    repeat (2) begin
      press_btns(1'b0, 1'b1, $urandom_range(DEB + 1, DEB + 6), e);
      repeat ($urandom_range(2, 9)) @(negedge clk);
    end
    sync_model();
    for (int j = 0; j < 16 && ((cyc - anchor) % 4) != 3; j++) @(negedge clk);
    sync_model();
    rst_n = 1'b0;
    @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    n_cmp++;
    if (en_log[r] !== 1'b0 || run_log[r] !== 1'b0 || lvl_log[r] !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid got en=%b run=%b lvl=%0d want 0 0 0 (pre lvl=%0d)",
               en_log[r], run_log[r], lvl_log[r], lvl_log[r - 1]);
    end
    m_run = 0;
    m_lvl = 0;
    anchor = r;
    exp_en[r] = 1'b0;
    exp_run[r] = 1'b0;
    exp_lvl[r] = 2'd0;
    model_pos = r + 1;
    repeat (3) @(negedge clk);
    press_btns(1'b1, 1'b1, $urandom_range(DEB + 1, DEB + 6), e);
    repeat (3 * 8 + 4) @(negedge clk);
    sync_model();
    n_cmp++;
    if (run_log[cyc] !== 1'b1 || lvl_log[cyc] !== 2'd1 || en_log[e + 8] !== 1'b1) begin
      n_err++;
      $display("FAIL both_press got run=%b lvl=%0d en@8=%b want run=1 lvl=1 en=1",
               run_log[cyc], lvl_log[cyc], en_log[e + 8]);
    end
    for (int c = a; c < model_pos; c++) begin
      n_cmp++;
      if (en_log[c] !== exp_en[c] || run_log[c] !== exp_run[c] || lvl_log[c] !== exp_lvl[c]) begin
        n_err++;
        $display("FAIL reset_mid c=%0d got en=%b run=%b lvl=%0d want en=%b run=%b lvl=%0d",
                 c, en_log[c], run_log[c], lvl_log[c], exp_en[c], exp_run[c], exp_lvl[c]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_glitch();
    test_speed();
    test_pause_resume();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
